// File: rtl/mem_req_queue_if.sv
// rtl/mem_req_queue_if.sv - handshake and slot-view bundle for the memory request queue
//
// Purpose: groups the push/pop handshake and the per-slot observation bus.
// Signals:
//   push_valid/push_ready/push_core/push_op/push_addr : request insertion handshake
//   pop_valid/pop_idx                                 : scheduler removal of one slot
//   ent_valid/ent_addr/ent_op/ent_core                : flattened per-slot contents
//   head_age/count/full/empty/starve/pop_err          : queue status
// Modports: master drives push/pop (scheduler side), slave is the queue.
interface mem_req_queue_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 34,
    parameter int CORE_W = 4,
    parameter int OP_W   = 2,
    parameter int AGE_W  = 8
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       push_valid;
    logic                       push_ready;
    logic [CORE_W-1:0]          push_core;
    logic [OP_W-1:0]            push_op;
    logic [ADDR_W-1:0]          push_addr;
    logic                       pop_valid;
    logic [IDX_W-1:0]           pop_idx;
    logic [DEPTH-1:0]           ent_valid;
    logic [DEPTH*ADDR_W-1:0]    ent_addr;
    logic [DEPTH*OP_W-1:0]      ent_op;
    logic [DEPTH*CORE_W-1:0]    ent_core;
    logic [AGE_W-1:0]           head_age;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       starve;
    logic                       pop_err;

    modport master (
        output push_valid, push_core, push_op, push_addr, pop_valid, pop_idx,
        input  push_ready, ent_valid, ent_addr, ent_op, ent_core,
        input  head_age, count, full, empty, starve, pop_err
    );

    modport slave (
        input  push_valid, push_core, push_op, push_addr, pop_valid, pop_idx,
        output push_ready, ent_valid, ent_addr, ent_op, ent_core,
        output head_age, count, full, empty, starve, pop_err
    );
endinterface

// File: rtl/mem_req_queue.sv
// rtl/mem_req_queue.sv - age-ordered compacting memory request queue
//
// Purpose: holds up to DEPTH requests ordered oldest-first in slots 0..count-1.
// Any slot may be removed; younger slots slide down to keep the queue compacted.
// Each valid slot carries a saturating age counter; starve flags an old head.
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   q     : mem_req_queue_if.slave (push/pop handshake, slot view, status)
module mem_req_queue #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 34,
    parameter int CORE_W     = 4,
    parameter int OP_W       = 2,
    parameter int AGE_W      = 8,
    parameter int STARVE_LIM = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_req_queue_if.slave     q
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [OP_W-1:0]   r_op   [DEPTH];
    logic [CORE_W-1:0] r_core [DEPTH];
    logic [AGE_W-1:0]  r_age  [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_pop_err;

    logic [ADDR_W-1:0] w_addr_nxt [DEPTH];
    logic [OP_W-1:0]   w_op_nxt   [DEPTH];
    logic [CORE_W-1:0] w_core_nxt [DEPTH];
    logic [AGE_W-1:0]  w_age_nxt  [DEPTH];
    logic [CNT_W-1:0]  w_pop_idx;
    logic [CNT_W-1:0]  w_cnt_after_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_push_ok;
    logic              w_pop_ok;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == '1) ? a : a + 1'b1;
    endfunction

    // push_ready looks only at the registered count: a pop in the same cycle
    // never opens room for a push into a full queue.
    assign w_pop_idx       = CNT_W'(q.pop_idx);
    assign w_push_ok       = q.push_valid && (r_count < CNT_W'(DEPTH));
    assign w_pop_ok        = q.pop_valid && (w_pop_idx < r_count);
    assign w_cnt_after_pop = r_count - CNT_W'(w_pop_ok);
    assign w_count_nxt     = w_cnt_after_pop + CNT_W'(w_push_ok);

    // Removal is resolved first, then the new entry lands just above the
    // surviving entries. Slots at or above the popped index take the contents
    // of the slot above; the modulo never wraps in practice because a pop
    // leaves at most DEPTH-1 survivors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_addr_nxt[i] = '0;
            w_op_nxt[i]   = '0;
            w_core_nxt[i] = '0;
            w_age_nxt[i]  = '0;
            if (CNT_W'(i) < w_cnt_after_pop) begin
                if (w_pop_ok && (CNT_W'(i) >= w_pop_idx)) begin
                    w_addr_nxt[i] = r_addr[(i + 1) % DEPTH];
                    w_op_nxt[i]   = r_op[(i + 1) % DEPTH];
                    w_core_nxt[i] = r_core[(i + 1) % DEPTH];
                    w_age_nxt[i]  = age_inc(r_age[(i + 1) % DEPTH]);
                end else begin
                    w_addr_nxt[i] = r_addr[i];
                    w_op_nxt[i]   = r_op[i];
                    w_core_nxt[i] = r_core[i];
                    w_age_nxt[i]  = age_inc(r_age[i]);
                end
            end else if (w_push_ok && (CNT_W'(i) == w_cnt_after_pop)) begin
                w_addr_nxt[i] = q.push_addr;
                w_op_nxt[i]   = q.push_op;
                w_core_nxt[i] = q.push_core;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_op[i]   <= '0;
                r_core[i] <= '0;
                r_age[i]  <= '0;
            end
            r_count   <= '0;
            r_pop_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= w_addr_nxt[i];
                r_op[i]   <= w_op_nxt[i];
                r_core[i] <= w_core_nxt[i];
                r_age[i]  <= w_age_nxt[i];
            end
            r_count   <= w_count_nxt;
            r_pop_err <= q.pop_valid && !w_pop_ok;
        end
    end

    // Invalid slots are held at zero, so the slot view needs no masking.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign q.ent_valid[gi]                   = (CNT_W'(gi) < r_count);
        assign q.ent_addr[gi*ADDR_W +: ADDR_W]   = r_addr[gi];
        assign q.ent_op[gi*OP_W +: OP_W]         = r_op[gi];
        assign q.ent_core[gi*CORE_W +: CORE_W]   = r_core[gi];
    end

    assign q.push_ready = (r_count < CNT_W'(DEPTH));
    assign q.count      = r_count;
    assign q.full       = (r_count == CNT_W'(DEPTH));
    assign q.empty      = (r_count == '0);
    assign q.head_age   = r_age[0];
    assign q.starve     = (r_count != '0) && (r_age[0] >= AGE_W'(STARVE_LIM));
    assign q.pop_err    = r_pop_err;
endmodule
